// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-outstanding instruction fetch FSM with redirect squashing.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  output logic        misalign,
  output logic [7:0]  squash_count
);
  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, DRAIN} state_t;
  state_t state, state_nxt;
  logic accept, capture, squash;
  assign accept    = imem_req & imem_ready;
  assign capture   = (state == WAIT) & imem_rvalid & ~redirect_valid;
  assign squash    = redirect_valid & (((state == REQ) & accept) | (state == WAIT) | (state == HOLD));
  assign imem_addr = pc_out;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:  state_nxt = REQ;
      REQ:   state_nxt = accept ? (redirect_valid ? DRAIN : WAIT) : REQ;
      WAIT:  state_nxt = redirect_valid ? (imem_rvalid ? REQ : DRAIN) : (imem_rvalid ? HOLD : WAIT);
      HOLD:  state_nxt = (redirect_valid | instr_ready) ? REQ : HOLD;
      DRAIN: state_nxt = imem_rvalid ? REQ : DRAIN;
      default: state_nxt = BOOT;
    endcase
  end
  always_comb imem_req = (state == REQ) & ~stall;
  // instr_valid is only ever set on the way into HOLD, so clearing on ready/redirect suffices
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_out       <= RESET_PC;
      instr_valid  <= 1'b0;
      instr        <= '0;
      instr_pc     <= '0;
      misalign     <= 1'b0;
      squash_count <= '0;
    end else begin
      misalign    <= redirect_valid & |redirect_pc[1:0];
      instr_valid <= capture | (instr_valid & ~(instr_ready | redirect_valid));
      if (redirect_valid) pc_out <= {redirect_pc[31:2], 2'b00};
      else if (capture)   pc_out <= pc_out + 32'd4;
      if (capture) begin
        instr    <= imem_rdata;
        instr_pc <= pc_out;
      end
      if (squash && squash_count != 8'hFF) squash_count <= squash_count + 8'd1;
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch_sequencer against a latency-programmable memory.
module tb_fetch_sequencer;
  localparam logic [31:0] RPC   = 32'h0040_0000;
  localparam logic [31:0] MAGIC = 32'hA5A5_0F0F;
  logic clk = 0, rst_n = 0, stall = 0, redirect_valid = 0;
  logic [31:0] redirect_pc = '0;
  logic imem_req, imem_ready = 1, imem_rvalid = 0, instr_ready = 1;
  logic [31:0] imem_addr, imem_rdata = '0, instr, instr_pc, pc_out;
  logic instr_valid, misalign;
  logic [7:0] squash_count;
  int errors = 0, checks = 0, lat = 0, cnt = 0;
  logic pend = 0;
  logic [31:0] paddr = '0;

  fetch_sequencer #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .pc_out(pc_out), .misalign(misalign),
    .squash_count(squash_count));

  always #5 clk = ~clk;

  // memory keeps running through DUT reset so stale responses can arrive
  always @(posedge clk) begin
    imem_rvalid <= 1'b0;
    if (pend) begin
      if (cnt == 0) begin imem_rvalid <= 1'b1; imem_rdata <= paddr ^ MAGIC; pend <= 1'b0; end
      else cnt <= cnt - 1;
    end
    if (imem_req && imem_ready) begin
      paddr <= imem_addr;
      if (lat == 0) begin imem_rvalid <= 1'b1; imem_rdata <= imem_addr ^ MAGIC; end
      else begin pend <= 1'b1; cnt <= lat - 1; end
    end
  end

  task automatic tick; @(negedge clk); endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) tick();
    checks++; if (pc_out !== RPC) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_out, RPC); end
    checks++; if (instr_valid !== 1'b0 || instr !== '0 || instr_pc !== '0) begin errors++; $display("FAIL reset_instr: got v=%b i=%h pc=%h expected 0", instr_valid, instr, instr_pc); end
    checks++; if (squash_count !== 8'd0 || misalign !== 1'b0) begin errors++; $display("FAIL reset_misc: got sq=%0d mis=%b expected 0", squash_count, misalign); end
    rst_n = 1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b expected 0", imem_req); end
    tick();
  endtask

  task automatic test_fetch_loop;
    for (int k = 0; k < 9; k++) begin
      logic [31:0] a;
      a = RPC + 32'(4 * (k / 3));
      checks++; if (imem_req !== (k % 3 == 0) || (k % 3 == 0 && imem_addr !== a)) begin errors++; $display("FAIL loop_req k=%0d: got req=%b addr=%h expected req=%b addr=%h", k, imem_req, imem_addr, k % 3 == 0, a); end
      checks++; if (instr_valid !== (k % 3 == 2) || (k % 3 == 2 && (instr_pc !== a || instr !== (a ^ MAGIC)))) begin errors++; $display("FAIL loop_instr k=%0d: got v=%b pc=%h i=%h expected v=%b pc=%h", k, instr_valid, instr_pc, instr, k % 3 == 2, a); end
      tick();
    end
  endtask

  task automatic test_stall;
    stall = 1; #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req !== 1'b0 || pc_out !== 32'h0040_000c) begin errors++; $display("FAIL stall_hold i=%0d: got req=%b pc=%h expected req=0 pc=0040000c", i, imem_req, pc_out); end
      tick();
    end
    stall = 0; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_000c) begin errors++; $display("FAIL stall_resume: got req=%b addr=%h expected req=1 addr=0040000c", imem_req, imem_addr); end
    repeat (2) tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0040_000c) begin errors++; $display("FAIL stall_fetch: got v=%b pc=%h expected v=1 pc=0040000c", instr_valid, instr_pc); end
    tick();
  endtask

  task automatic test_redirect_wait;
    logic found, stale;
    lat = 3; instr_ready = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) if (imem_req) found = 1; else tick();
    tick();
    redirect_valid = 1; redirect_pc = 32'h0000_1000;
    tick();
    redirect_valid = 0;
    checks++; if (squash_count !== 8'd1 || pc_out !== 32'h1000 || imem_req !== 1'b0) begin errors++; $display("FAIL wait_redirect: got sq=%0d pc=%h req=%b expected sq=1 pc=00001000 req=0", squash_count, pc_out, imem_req); end
    lat = 0; found = 0; stale = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      stale |= instr_valid;
      if (imem_req) found = 1; else tick();
    end
    checks++; if (!found || imem_addr !== 32'h1000) begin errors++; $display("FAIL wait_newreq: got found=%b addr=%h expected found=1 addr=00001000", found, imem_addr); end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL wait_stale: got presented=%b expected 0", stale); end
    instr_ready = 0; found = 0;
    for (int i = 0; i < 10 && !found; i++) if (instr_valid) found = 1; else tick();
    checks++; if (!found || instr_pc !== 32'h1000 || instr !== (32'h1000 ^ MAGIC)) begin errors++; $display("FAIL wait_refetch: got v=%b pc=%h i=%h expected pc=00001000", found, instr_pc, instr); end
  endtask

  task automatic test_redirect_hold;
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h1000) begin errors++; $display("FAIL hold_stable: got v=%b pc=%h expected v=1 pc=00001000", instr_valid, instr_pc); end
    instr_ready = 1; redirect_valid = 1; redirect_pc = 32'h0000_2000;
    tick();
    redirect_valid = 0;
    checks++; if (instr_valid !== 1'b0 || squash_count !== 8'd2 || misalign !== 1'b0) begin errors++; $display("FAIL hold_redirect: got v=%b sq=%0d mis=%b expected v=0 sq=2 mis=0", instr_valid, squash_count, misalign); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin errors++; $display("FAIL hold_newreq: got req=%b addr=%h expected req=1 addr=00002000", imem_req, imem_addr); end
  endtask

  task automatic test_misalign;
    stall = 1; redirect_valid = 1; redirect_pc = 32'h0000_1002;
    tick();
    redirect_valid = 0; stall = 0; #1;
    checks++; if (pc_out !== 32'h1000 || misalign !== 1'b1 || squash_count !== 8'd2) begin errors++; $display("FAIL misalign: got pc=%h mis=%b sq=%0d expected pc=00001000 mis=1 sq=2", pc_out, misalign, squash_count); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h1000) begin errors++; $display("FAIL misalign_req: got req=%b addr=%h expected req=1 addr=00001000", imem_req, imem_addr); end
    tick();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL misalign_pulse: got %b expected 0", misalign); end
  endtask

  task automatic test_redirect_cases;
    logic found;
    redirect_valid = 1; redirect_pc = 32'h0000_3000;
    tick();
    checks++; if (instr_valid !== 1'b0 || squash_count !== 8'd3 || imem_req !== 1'b1 || imem_addr !== 32'h3000) begin errors++; $display("FAIL capture_redirect: got v=%b sq=%0d req=%b addr=%h expected v=0 sq=3 req=1 addr=00003000", instr_valid, squash_count, imem_req, imem_addr); end
    lat = 2; redirect_pc = 32'h0000_4000;
    tick();
    checks++; if (squash_count !== 8'd4 || pc_out !== 32'h4000 || imem_req !== 1'b0) begin errors++; $display("FAIL accept_redirect: got sq=%0d pc=%h req=%b expected sq=4 pc=00004000 req=0", squash_count, pc_out, imem_req); end
    redirect_pc = 32'h0000_5000;
    tick();
    redirect_valid = 0;
    checks++; if (squash_count !== 8'd4 || pc_out !== 32'h5000 || imem_req !== 1'b0) begin errors++; $display("FAIL drain_redirect: got sq=%0d pc=%h req=%b expected sq=4 pc=00005000 req=0", squash_count, pc_out, imem_req); end
    lat = 0; found = 0;
    for (int i = 0; i < 10 && !found; i++) if (imem_req) found = 1; else tick();
    checks++; if (!found || imem_addr !== 32'h5000) begin errors++; $display("FAIL drain_newreq: got found=%b addr=%h expected addr=00005000", found, imem_addr); end
  endtask

  task automatic test_wrap;
    logic found;
    stall = 1; redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 0; stall = 0; found = 0;
    for (int i = 0; i < 10 && !found; i++) if (instr_valid) found = 1; else tick();
    checks++; if (!found || instr_pc !== 32'hFFFF_FFFC || instr !== (32'hFFFF_FFFC ^ MAGIC) || pc_out !== 32'h0) begin errors++; $display("FAIL wrap: got v=%b ipc=%h pc=%h expected ipc=fffffffc pc=00000000", found, instr_pc, pc_out); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_req: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
  endtask

  task automatic test_squash_sat;
    logic dropped;
    logic [7:0] prev;
    dropped = 0;
    redirect_valid = 1; redirect_pc = 32'h0000_0100;
    for (int i = 0; i < 620; i++) begin
      prev = squash_count;
      tick();
      if (squash_count < prev) dropped = 1;
    end
    redirect_valid = 0;
    checks++; if (squash_count !== 8'd255) begin errors++; $display("FAIL squash_sat: got %0d expected 255", squash_count); end
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL squash_wrap: got decrease=%b expected 0", dropped); end
  endtask

  task automatic test_reset_midop;
    logic found, bad;
    lat = 3; found = 0; bad = 0;
    for (int i = 0; i < 10 && !found; i++) if (imem_req) found = 1; else tick();
    tick();
    rst_n = 0; #1;
    checks++; if (pc_out !== RPC || squash_count !== 8'd0 || instr_valid !== 1'b0) begin errors++; $display("FAIL async_reset: got pc=%h sq=%0d v=%b expected pc=%h sq=0 v=0", pc_out, squash_count, instr_valid, RPC); end
    tick();
    stall = 1; rst_n = 1;
    for (int i = 0; i < 5; i++) begin tick(); bad |= instr_valid | imem_req; end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL stale_rvalid: got activity=%b expected 0", bad); end
    lat = 0; stall = 0; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin errors++; $display("FAIL post_reset_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RPC); end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) if (instr_valid) found = 1; else tick();
    checks++; if (!found || instr_pc !== RPC || instr !== (RPC ^ MAGIC)) begin errors++; $display("FAIL post_reset_fetch: got v=%b pc=%h i=%h expected pc=%h", found, instr_pc, instr, RPC); end
  endtask

  initial begin
    test_reset();
    test_fetch_loop();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_misalign();
    test_redirect_cases();
    test_wrap();
    test_squash_sat();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
